// File: rtl/firebird7_in_gate2_ijtag_tdr_access_ctrl.sv
// ============================================================================
// firebird7_in_gate2_ijtag_tdr_access_ctrl
//
// Host-side IJTAG access sequencer for the gate2 TDR chain. One parallel
// request is turned into a complete TDR access on ijtag_tck:
//   select -> capture (1 cycle) -> shift (len+1 cycles) -> update (1 cycle)
// and the bits shifted out of the chain are returned as a response.
//
// All sequencing state and every ijtag_* output change on the falling edge of
// TCK, so the TDRs on the chain see stable controls at the rising edge. Scan
// data returning from the chain is sampled on the rising edge.
//
// Ports
//   i_ijtag_tck    TCK
//   i_ijtag_reset  asynchronous, active-low reset
//   i_req_valid    request present
//   o_req_ready    controller idle and able to accept a request
//   i_req_len      shift cycles minus one; values above CHAIN_LEN-1 are clamped
//   i_req_wdata    scan-in data, bit 0 shifted first
//   o_rsp_valid    response present, held until accepted
//   i_rsp_ready    response consumer ready
//   o_rsp_rdata    scan-out data, bit 0 = first bit out, unused MSBs are 0
//   o_ijtag_sel    chain select
//   o_ijtag_ce     capture enable
//   o_ijtag_se     shift enable
//   o_ijtag_ue     update enable
//   o_ijtag_si     scan data to the chain
//   i_ijtag_so     scan data from the chain (retimed, stable in TCK low phase)
// ============================================================================
module firebird7_in_gate2_ijtag_tdr_access_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int LEN_W     = $clog2(CHAIN_LEN) + 1
) (
  input  logic                 i_ijtag_tck,
  input  logic                 i_ijtag_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [LEN_W-1:0]     i_req_len,
  input  logic [CHAIN_LEN-1:0] i_req_wdata,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [CHAIN_LEN-1:0] o_rsp_rdata,
  output logic                 o_ijtag_sel,
  output logic                 o_ijtag_ce,
  output logic                 o_ijtag_se,
  output logic                 o_ijtag_ue,
  output logic                 o_ijtag_si,
  input  logic                 i_ijtag_so
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0]     LEN_MAX   = LEN_W'(CHAIN_LEN - 1);
  localparam logic [LEN_W-1:0]     LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]     LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [CHAIN_LEN-1:0] DATA_ZERO = {CHAIN_LEN{1'b0}};

  // Sequencing state (falling-edge domain)
  state_t               r_state;
  state_t               w_state_nxt;
  logic [LEN_W-1:0]     r_cnt;
  logic [LEN_W-1:0]     w_cnt_nxt;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     w_len_nxt;
  logic [LEN_W-1:0]     w_len_clamped;
  logic [CHAIN_LEN-1:0] r_shreg;
  logic [CHAIN_LEN-1:0] w_shreg_nxt;
  logic [CHAIN_LEN-1:0] w_shreg_shifted;

  // Registered outputs (falling-edge domain)
  logic r_req_ready;
  logic r_rsp_valid;
  logic r_sel;
  logic r_ce;
  logic r_se;
  logic r_ue;
  logic r_si;
  logic w_req_ready_nxt;
  logic w_rsp_valid_nxt;
  logic w_sel_nxt;
  logic w_ce_nxt;
  logic w_se_nxt;
  logic w_ue_nxt;
  logic w_si_nxt;

  // Scan-out collection (rising-edge domain)
  logic [CHAIN_LEN-1:0] r_rdata;
  logic [LEN_W-1:0]     w_idx;

  // Clamp an oversized length request to the physical chain length.
  always_comb begin
    if (i_req_len > LEN_MAX) begin
      w_len_clamped = LEN_MAX;
    end else begin
      w_len_clamped = i_req_len;
    end
  end

  // Shift register as it will look after the next shift step; its bit 0 is
  // the next bit to drive onto si.
  assign w_shreg_shifted = r_shreg >> 1;

  // Bit position for the sample taken this cycle: the counter runs down from
  // len, so the first bit out lands in bit 0.
  assign w_idx = r_len - r_cnt;

  // Next-state and next-output decode. Outputs are decoded from the state
  // being entered so that, once registered, they match the current state.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_len_nxt       = r_len;
    w_shreg_nxt     = r_shreg;
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_sel_nxt       = 1'b0;
    w_ce_nxt        = 1'b0;
    w_se_nxt        = 1'b0;
    w_ue_nxt        = 1'b0;
    w_si_nxt        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_state_nxt = ST_CAPTURE;
          w_shreg_nxt = i_req_wdata;
          w_cnt_nxt   = w_len_clamped;
          w_len_nxt   = w_len_clamped;
          w_sel_nxt   = 1'b1;
          w_ce_nxt    = 1'b1;
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end

      ST_CAPTURE: begin
        // First shift cycle drives the unshifted LSB.
        w_state_nxt = ST_SHIFT;
        w_sel_nxt   = 1'b1;
        w_se_nxt    = 1'b1;
        w_si_nxt    = r_shreg[0];
      end

      ST_SHIFT: begin
        if (r_cnt == LEN_ZERO) begin
          w_state_nxt = ST_UPDATE;
          w_sel_nxt   = 1'b1;
          w_ue_nxt    = 1'b1;
        end else begin
          w_shreg_nxt = w_shreg_shifted;
          w_cnt_nxt   = r_cnt - LEN_ONE;
          w_sel_nxt   = 1'b1;
          w_se_nxt    = 1'b1;
          w_si_nxt    = w_shreg_shifted[0];
        end
      end

      ST_UPDATE: begin
        w_state_nxt     = ST_RESP;
        w_rsp_valid_nxt = 1'b1;
      end

      ST_RESP: begin
        // After the handshake the controller spends at least one cycle in
        // IDLE, so a request held high is never accepted on this edge.
        if (i_rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_req_ready_nxt = 1'b1;
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
      end
    endcase
  end

  // State, counter, latched length and shift register on the falling edge.
  always_ff @(negedge i_ijtag_tck or negedge i_ijtag_reset) begin
    if (!i_ijtag_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= LEN_ZERO;
      r_len   <= LEN_ZERO;
      r_shreg <= DATA_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  // Registered handshake and chain control outputs on the falling edge.
  always_ff @(negedge i_ijtag_tck or negedge i_ijtag_reset) begin
    if (!i_ijtag_reset) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_sel       <= 1'b0;
      r_ce        <= 1'b0;
      r_se        <= 1'b0;
      r_ue        <= 1'b0;
      r_si        <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_sel       <= w_sel_nxt;
      r_ce        <= w_ce_nxt;
      r_se        <= w_se_nxt;
      r_ue        <= w_ue_nxt;
      r_si        <= w_si_nxt;
    end
  end

  // Scan-out collection on the rising edge: cleared during capture, then one
  // bit per shift cycle, held untouched through update and response.
  always_ff @(posedge i_ijtag_tck or negedge i_ijtag_reset) begin
    if (!i_ijtag_reset) begin
      r_rdata <= DATA_ZERO;
    end else if (r_state == ST_CAPTURE) begin
      r_rdata <= DATA_ZERO;
    end else if (r_se) begin
      for (int i = 0; i < CHAIN_LEN; i++) begin
        if (w_idx == LEN_W'(i)) begin
          r_rdata[i] <= i_ijtag_so;
        end else begin
          r_rdata[i] <= r_rdata[i];
        end
      end
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_ijtag_sel = r_sel;
  assign o_ijtag_ce  = r_ce;
  assign o_ijtag_se  = r_se;
  assign o_ijtag_ue  = r_ue;
  assign o_ijtag_si  = r_si;

endmodule

// File: tb/tb_firebird7_in_gate2_ijtag_tdr_access_ctrl.sv
// Bench for the gate2 IJTAG TDR access sequencer. A behavioural TDR of
// selectable length (1..8 bits, programmable capture value, reset value all
// ones) sits on the chain; an optional loopback routes si straight to so.
module tb_firebird7_in_gate2_ijtag_tdr_access_ctrl;

  localparam int CHAIN_LEN = 8;
  localparam int LEN_W     = 4;

  logic                 tck;
  logic                 rst_n;
  logic                 req_valid;
  logic                 req_ready;
  logic [LEN_W-1:0]     req_len;
  logic [CHAIN_LEN-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [CHAIN_LEN-1:0] rsp_rdata;
  logic                 sel, ce, se, ue, si;
  logic                 so;

  firebird7_in_gate2_ijtag_tdr_access_ctrl #(
    .CHAIN_LEN (CHAIN_LEN),
    .LEN_W     (LEN_W)
  ) dut (
    .i_ijtag_tck   (tck),
    .i_ijtag_reset (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_len     (req_len),
    .i_req_wdata   (req_wdata),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_rdata   (rsp_rdata),
    .o_ijtag_sel   (sel),
    .o_ijtag_ce    (ce),
    .o_ijtag_se    (se),
    .o_ijtag_ue    (ue),
    .o_ijtag_si    (si),
    .i_ijtag_so    (so)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  // ---------------- behavioural TDR on the chain ----------------
  int         tdr_len;
  logic [7:0] tdr_mask;
  logic [7:0] tdr_cap;
  logic       loop_en;
  logic [7:0] tdr_sr;
  logic [7:0] tdr_dout;
  logic       tdr_so;

  function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b, input int n);
    logic [7:0] t;
    t = v >> 1;
    for (int i = 0; i < 8; i++) if (i == n - 1) t[i] = b;
    return t;
  endfunction

  function automatic logic [7:0] len_mask(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  always @(posedge tck or negedge rst_n) begin
    if (!rst_n) tdr_sr <= 8'h00;
    else if (sel && ce) tdr_sr <= tdr_cap & tdr_mask;
    else if (sel && se) tdr_sr <= shift_in(tdr_sr, si, tdr_len);
  end

  always @(negedge tck or negedge rst_n) begin
    if (!rst_n) begin
      tdr_so   <= 1'b0;
      tdr_dout <= 8'hFF;
    end else begin
      tdr_so <= tdr_sr[0];
      if (sel && ue) tdr_dout <= tdr_sr;
    end
  end

  assign so = loop_en ? si : tdr_so;

  // ---------------- checking ----------------
  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] len;
    logic [7:0] wdata;
    logic [7:0] cap;
    logic       loop;
    int         tlen;
    logic [7:0] exp_rdata;
    logic [7:0] exp_dout;
    int         exp_cyc;
    int         exp_se;
  } vec_t;

  vec_t vecs[8];

  // Issue one access; called right after a rising edge with the DUT idle.
  // Cycles are counted from the accept cycle to the first edge with rsp_valid.
  task automatic run_vec(input int id, input vec_t v, input int hold, input bit keep_valid);
    int         cyc, se_n, ce_n, ue_n, excl_bad, stab_bad;
    bit         got;
    logic [7:0] rd_held;
    string      nm;
    cyc = 0; se_n = 0; ce_n = 0; ue_n = 0; excl_bad = 0; stab_bad = 0; got = 1'b0;
    nm = $sformatf("v%0d", id);
    tdr_len  = v.tlen;
    tdr_mask = len_mask(v.tlen);
    tdr_cap  = v.cap;
    loop_en  = v.loop;
    check({nm, " ready_before"}, 32'(req_ready), 32'd1);
    req_len   = v.len;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge tck);
      if (!keep_valid) req_valid = 1'b0;
      cyc++;
      if (se) se_n++;
      if (ce) ce_n++;
      if (ue) ue_n++;
      if ((ce && se) || (ce && ue) || (se && ue) || ((ce || se || ue) && !sel)) excl_bad++;
      if (rsp_valid) got = 1'b1;
    end
    check({nm, " rsp_valid_seen"}, 32'(got), 32'd1);
    check({nm, " cycles"}, cyc, v.exp_cyc);
    check({nm, " se_cycles"}, se_n, v.exp_se);
    check({nm, " ce_cycles"}, ce_n, 32'd1);
    check({nm, " ue_cycles"}, ue_n, 32'd1);
    check({nm, " exclusive"}, excl_bad, 32'd0);
    check({nm, " rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    check({nm, " tdr_dout"}, 32'(tdr_dout & tdr_mask), 32'(v.exp_dout));
    rd_held = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(posedge tck);
      if (!rsp_valid || rsp_rdata !== rd_held || req_ready || sel) stab_bad++;
    end
    if (hold > 0) check({nm, " hold_stable"}, stab_bad, 32'd0);
    rsp_ready = 1'b1;
    @(posedge tck);
    rsp_ready = 1'b0;
    check({nm, " rsp_valid_after_hs"}, 32'(rsp_valid), 32'd0);
    check({nm, " ready_after_hs"}, 32'(req_ready), 32'd1);
    check({nm, " ce_after_hs"}, 32'(ce), 32'd0);
    if (keep_valid) begin
      @(posedge tck);
      req_valid = 1'b0;
      check({nm, " b2b_ce"}, 32'(ce), 32'd1);
      check({nm, " b2b_ready"}, 32'(req_ready), 32'd0);
    end
  endtask

  // Wait for an already-running access to complete and acknowledge it.
  task automatic drain(input string nm, input logic [7:0] exp_rdata);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(posedge tck);
      if (rsp_valid) got = 1'b1;
    end
    check({nm, " rsp_valid_seen"}, 32'(got), 32'd1);
    check({nm, " rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    rsp_ready = 1'b1;
    @(posedge tck);
    rsp_ready = 1'b0;
    check({nm, " rsp_valid_after_hs"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    int bad;
    n_cmp = 0;
    n_bad = 0;
    //          len    wdata  cap    loop tl rdata  dout  cyc se
    vecs[0] = '{4'd0,  8'h00, 8'h00, 1'b0, 1, 8'h00, 8'h00, 4, 1};
    vecs[1] = '{4'd2,  8'h05, 8'h00, 1'b0, 3, 8'h00, 8'h05, 6, 3};
    vecs[2] = '{4'd2,  8'h05, 8'h00, 1'b0, 3, 8'h00, 8'h05, 6, 3};
    vecs[3] = '{4'd2,  8'h05, 8'h06, 1'b0, 3, 8'h06, 8'h05, 6, 3};
    vecs[4] = '{4'd7,  8'hA5, 8'h00, 1'b1, 8, 8'hA5, 8'hA5, 11, 8};
    vecs[5] = '{4'd12, 8'h5A, 8'hC3, 1'b0, 8, 8'hC3, 8'h5A, 11, 8};
    vecs[6] = '{4'd3,  8'hF9, 8'hFE, 1'b0, 4, 8'h0E, 8'h09, 7, 4};
    vecs[7] = '{4'd4,  8'h15, 8'h0A, 1'b0, 5, 8'h0A, 8'h15, 8, 5};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_len = 4'd0; req_wdata = 8'h00;
    tdr_len = 1; tdr_mask = 8'h01; tdr_cap = 8'h00; loop_en = 1'b0;
    repeat (3) @(posedge tck);
    check("reset sel", 32'(sel), 32'd0);
    check("reset ce", 32'(ce), 32'd0);
    check("reset se", 32'(se), 32'd0);
    check("reset ue", 32'(ue), 32'd0);
    check("reset si", 32'(si), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rdata", 32'(rsp_rdata), 32'd0);
    check("reset ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge tck);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i], (i == 1) ? 5 : 0, 1'b0);
    end

    // Request held high through a stalled response: next one starts one
    // cycle after the handshake, then runs to completion.
    run_vec(8, vecs[3], 5, 1'b1);
    drain("b2b second", 8'h06);

    // Reset in the second shift cycle of an 8-bit access.
    tdr_len = 8; tdr_mask = 8'hFF; tdr_cap = 8'h5A; loop_en = 1'b0;
    req_len = 4'd7; req_wdata = 8'hFF; req_valid = 1'b1;
    @(posedge tck);
    req_valid = 1'b0;
    check("abort ce", 32'(ce), 32'd1);
    @(posedge tck);
    @(posedge tck);
    check("abort se", 32'(se), 32'd1);
    check("abort si", 32'(si), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort sel", 32'(sel), 32'd0);
    check("abort se_low", 32'(se), 32'd0);
    check("abort si_low", 32'(si), 32'd0);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort rdata", 32'(rsp_rdata), 32'd0);
    check("abort ready", 32'(req_ready), 32'd1);
    @(posedge tck);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge tck);
      if (rsp_valid || sel || ue) bad++;
    end
    check("abort quiet", bad, 32'd0);
    check("abort tdr_dout", 32'(tdr_dout), 32'hFF);

    run_vec(9, vecs[5], 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
